// File: rtl/lfsr_pseq_pkg.sv
// Shared types and constants for the LFSR pattern sequencer.
// Covers the x^6 + x^5 + 1 step function with its all-zero escape.
package lfsr_pseq_pkg;

    localparam int unsigned LFSR_W = 6;
    localparam int unsigned TAP_HI = 5;
    localparam int unsigned TAP_LO = 4;
    localparam logic [LFSR_W-1:0] ZERO_STATE = '0;

    // Sequencer states, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StLoad = 2'd1;
    localparam state_t StRun  = 2'd2;
    localparam state_t StDone = 2'd3;

    // The NOR term forces a 1 in so the all-zero lockup state steps to 0x01.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = (s[TAP_HI] ^ s[TAP_LO]) | (s == ZERO_STATE);
        return {s[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr6_core.sv
// 6-bit Type 1 LFSR register with synchronous reset, parallel load and step enable.
// Load takes priority over enable.
module lfsr6_core
    import lfsr_pseq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [LFSR_W-1:0] load_val_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_d, state_q;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ZERO_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_pattern_seq.sv
// Start/seed/count sequencer emitting LFSR states over a valid/ready stream.
// Define LFSR_PSEQ_SIG_EN to add the sig output and its signature register.
module lfsr_pattern_seq
    import lfsr_pseq_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               pat_valid,
    input  logic               pat_ready,
    output logic [LFSR_W-1:0]  pat_data,
    output logic               done
`ifdef LFSR_PSEQ_SIG_EN
    ,
    output logic [LFSR_W-1:0]  sig
`endif
);

    state_t             state_d, state_q;
    logic [LFSR_W-1:0]  seed_d, seed_q;
    logic [COUNT_W-1:0] remaining_d, remaining_q;
    logic [LFSR_W-1:0]  lfsr_state;
    logic               lfsr_load;
    logic               handshake;
    logic               start_acc;

    assign handshake = (state_q == StRun) && pat_ready;
    assign start_acc = (state_q == StIdle) && start;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        remaining_d = remaining_q;
        lfsr_load   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    seed_d      = seed;
                    remaining_d = count;
                    state_d     = (count == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                lfsr_load = 1'b1;
                state_d   = StRun;
            end
            StRun: begin
                if (handshake) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            seed_q      <= ZERO_STATE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
        end
    end

    lfsr6_core u_lfsr (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (lfsr_load),
        .en_i       (handshake),
        .load_val_i (seed_q),
        .state_o    (lfsr_state)
    );

    assign busy      = (state_q != StIdle);
    assign pat_valid = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign pat_data  = lfsr_state;

`ifdef LFSR_PSEQ_SIG_EN
    logic [LFSR_W-1:0] sig_d, sig_q;

    // Signature shift has no zero escape, unlike the pattern LFSR.
    always_comb begin
        sig_d = sig_q;
        if (start_acc) begin
            sig_d = ZERO_STATE;
        end else if (handshake) begin
            sig_d = {sig_q[LFSR_W-2:0], sig_q[TAP_HI] ^ sig_q[TAP_LO]} ^ lfsr_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= ZERO_STATE;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_lfsr_pattern_seq.sv
// Self-checking bench for lfsr_pattern_seq: directed cases plus randomized transactions
// compared against an arithmetic pattern/signature model.
module tb_lfsr_pattern_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] seed;
    logic [7:0] count;
    logic       busy;
    logic       pat_valid;
    logic       pat_ready;
    logic [5:0] pat_data;
    logic       done;
`ifdef LFSR_PSEQ_SIG_EN
    logic [5:0] sig;
`endif

    int total = 0;
    int bad   = 0;
    int rdy_pat[5] = '{1, 0, 0, 1, 1};

    always #5 clk = ~clk;

    lfsr_pattern_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seed      (seed),
        .count     (count),
        .busy      (busy),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .done      (done)
`ifdef LFSR_PSEQ_SIG_EN
        ,
        .sig       (sig)
`endif
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Polynomial x^6 + x^5 + 1: feedback is bit5 xor bit4, zero state steps to 1.
    function automatic int model_step(input int s);
        int fb;
        fb = ((s / 32) + (s / 16)) % 2;
        if (s == 0) fb = 1;
        return ((s * 2) % 64) + fb;
    endfunction

    function automatic int sig_step(input int sg, input int d);
        int fb;
        fb = ((sg / 32) + (sg / 16)) % 2;
        return (((sg * 2) % 64) + fb) ^ d;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_valid"}, int'(pat_valid), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_data"}, int'(pat_data), 0);
`ifdef LFSR_PSEQ_SIG_EN
        check_val({tag, "_sig"}, int'(sig), 0);
`endif
    endtask

    // mode: 0 ready always high, 1 random ready, 2 ready follows rdy_pat
    task automatic run_txn(input int sd, input int cnt, input int mode, input bit busy_start);
        int  exp_q[$];
        int  s;
        int  msig;
        int  budget;
        int  cyc;
        bit  prev_stall;
        int  prev_data;
        s = sd;
        msig = 0;
        prev_stall = 1'b0;
        prev_data = 0;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(s);
            s = model_step(s);
        end
        seed = 6'(sd);
        count = 8'(cnt);
        start = 1'b1;
        pat_ready = 1'b0;
        #1;
        check_val("idle_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        if (cnt == 0) begin
            check_val("zero_done", int'(done), 1);
            check_val("zero_valid", int'(pat_valid), 0);
            check_val("zero_busy", int'(busy), 1);
        end else begin
            check_val("load_busy", int'(busy), 1);
            check_val("load_valid", int'(pat_valid), 0);
            check_val("load_done", int'(done), 0);
`ifdef LFSR_PSEQ_SIG_EN
            check_val("load_sig_clear", int'(sig), 0);
`endif
            budget = cnt * 8 + 20;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < budget) begin
                next_cycle();
                case (mode)
                    0: pat_ready = 1'b1;
                    1: pat_ready = ($urandom_range(0, 2) != 0);
                    default: pat_ready = (cyc < 5) ? rdy_pat[cyc] != 0 : 1'b1;
                endcase
                cyc++;
                start = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
                seed = 6'($urandom);
                count = 8'($urandom);
                @(negedge clk);
                check_val("run_valid", int'(pat_valid), 1);
                check_val("run_done", int'(done), 0);
                if (prev_stall) check_val("stall_hold", int'(pat_data), prev_data);
                check_val("run_data", int'(pat_data), exp_q[0]);
                if (pat_ready) begin
                    msig = sig_step(msig, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                prev_stall = !pat_ready;
                prev_data = int'(pat_data);
            end
            if (exp_q.size() > 0) check_val("run_timeout", exp_q.size(), 0);
            next_cycle();
            start = 1'b0;
            pat_ready = 1'b0;
            @(negedge clk);
            check_val("done_pulse", int'(done), 1);
            check_val("done_valid", int'(pat_valid), 0);
            check_val("done_busy", int'(busy), 1);
        end
`ifdef LFSR_PSEQ_SIG_EN
        check_val("sig_done", int'(sig), msig);
`endif
        next_cycle();
        @(negedge clk);
        check_val("post_busy", int'(busy), 0);
        check_val("post_done", int'(done), 0);
        check_val("post_valid", int'(pat_valid), 0);
    endtask

    task automatic reset_mid_run();
        int s;
        s = 6'h15;
        seed = 6'(s);
        count = 8'd5;
        start = 1'b1;
        pat_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rst_run_data", int'(pat_data), s);
            s = model_step(s);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            check_val("rst_no_done", int'(done), 0);
        end
        // Reset coincident with start must win.
        next_cycle();
        seed = 6'h3f;
        count = 8'd4;
        start = 1'b1;
        reset = 1'b1;
        next_cycle();
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_start");
        next_cycle();
        @(negedge clk);
        check_val("rst_start_idle", int'(busy), 0);
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        seed = '0;
        count = '0;
        pat_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        next_cycle();
        reset = 1'b0;
        next_cycle();

        run_txn(6'h01, 6, 0, 1'b0);
        run_txn(6'h01, 3, 2, 1'b0);
        run_txn(6'h00, 2, 0, 1'b0);
        run_txn(6'h2a, 0, 0, 1'b0);
        reset_mid_run();
        run_txn(6'h01, 3, 0, 1'b0);
        run_txn(6'h01, 3, 0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            run_txn(int'($urandom_range(0, 63)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 1)), 1'b1);
        end
        run_txn(int'($urandom_range(0, 63)), 255, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
